mem_request_arbiter: RTL and testbench
======================================

// Module: mem_request_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of the RAM/ROM memory controller front end.
//  Latches one requester's command (address, write data, chip/length/op selects) and issues it to
//  the controller. Waits for the controller's ack, or times out.
//  Returns read data with a one-cycle ack (or err) to the granted requester.
//  Lets a CPU port (0) and a DMA/display port (1) share the single external RAM/ROM path.
// PARAMETERS
//  ADDRESS_SIZE    24  width of memory address
//  DATA_SIZE       16  width of data word
//  TIMEOUT_CYCLES  64  WAIT cycles without mc_ack before the transaction is aborted (>=2)
// PORTS
//  clk                  in   1   single clock, rising edge
//  rst                  in   1   asynchronous, active-low reset
//  req0/req1            in   1   request; held high by requester until its ack/err pulse
//  addr0/addr1          in   ADDRESS_SIZE  request address
//  wdata0/wdata1        in   DATA_SIZE     write data
//  cs0/cs1              in   1   chip select (0=RAM, 1=ROM), passed to controller
//  len0/len1            in   1   length select (0=8-bit, 1=16-bit), passed to controller
//  op0/op1              in   1   operation (0=read, 1=write)
//  rdata0/rdata1        out  DATA_SIZE     read data; updated at that port's ack, held otherwise
//  ack0/ack1            out  1   one-cycle completion pulse
//  err0/err1            out  1   one-cycle timeout pulse (never together with ack)
//  gnt                  out  2   one-hot grant, high ISSUE..DONE
//  mc_valid             out  1   one-cycle command strobe to controller
//  mc_addr              out  ADDRESS_SIZE  latched address
//  mc_wdata             out  DATA_SIZE     latched write data
//  mc_chip_select       out  1   latched cs
//  mc_length_select     out  1   latched len
//  mc_op_select         out  1   latched op
//  mc_rdata             in   DATA_SIZE     controller read data, valid with mc_ack
//  mc_ack               in   1   controller operation complete
//  mc_ready             in   1   controller can accept a command
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, all outputs 0, timeout counter=0, last_grant=1 (port 0 wins first).
//  FSM states:
//   IDLE:  if (req0|req1) & mc_ready -> pick winner, latch its command into mc_* regs, set gnt -> ISSUE.
//          Else stay.
//   ISSUE: mc_valid=1 for exactly this cycle; counter cleared -> WAIT.
//   WAIT:  on mc_ack: capture mc_rdata, then -> DONE(ok).
//          Else counter++; at counter==TIMEOUT_CYCLES-1 -> DONE(err).
//   DONE:  pulse ackN (ok) or errN (timeout) for granted port; rdataN<=captured data on read ok only.
//          last_grant<=granted port; gnt<=0 -> IDLE.
//  Arbitration: only one request pending -> it wins. Both pending -> port != last_grant wins
//   (strict alternation under contention).
//  Latency: req sampled in IDLE at cycle t -> mc_valid t+1.
//   Fastest completion: mc_ack at t+2 -> ackN at t+3. Minimum request spacing is 4 cycles.
//  mc_* command outputs are stable from ISSUE through DONE. On writes, rdataN is unchanged.
//  mc_ack at the same cycle the counter hits its limit -> ack wins (ok, no err).
//  mc_ack in IDLE/ISSUE/DONE is ignored (spurious).
//  A requester dropping req mid-transaction does not abort it; ack/err is still pulsed.
//  Re-arbitration uses req levels sampled in IDLE only. A requester still high after its ack re-requests.
//  Reset mid-transaction: immediate return to reset state; no ack/err pulse is generated.
//  Counter width is clog2(TIMEOUT_CYCLES). It never wraps; it saturates at the limit.
// TESTING
//  T1 req0 read addr=0x000010, mc_ack at t+2 with mc_rdata=0xBEEF -> mc_valid t+1, ack0 t+3, rdata0=0xBEEF.
//  T2 req0 and req1 both high from reset, each acked after 3 cycles
//     -> grants in order 0,1,0,1; no ack1 before the first ack0.
//  T3 req1 write addr=0x00ABCD wdata=0x1234 cs=0 len=1
//     -> mc_addr=0x00ABCD, mc_wdata=0x1234, mc_op_select=1 during ISSUE; ack1; rdata1 unchanged.
//  T4 req0, never ack, TIMEOUT_CYCLES=8 -> err0 pulses at t+10, ack0 stays 0, FSM returns to IDLE.
//  T5 mc_ready=0 with req0 high for 5 cycles -> no mc_valid; mc_ready=1 -> mc_valid next cycle.
//  T6 rst low during WAIT -> all outputs 0 at once; after release, req1 alone is granted with no stale ack.

Source files
------------

// File: rtl/mem_request_arbiter_if.sv
// Bundles the two requester ports and the memory-controller command path.
// The slave modport faces the arbiter; the master modport faces requesters and the controller.
interface mem_request_arbiter_if #(
  parameter int unsigned ADDRESS_SIZE = 24,
  parameter int unsigned DATA_SIZE    = 16
);
  logic                    req0;
  logic                    req1;
  logic [ADDRESS_SIZE-1:0] addr0;
  logic [ADDRESS_SIZE-1:0] addr1;
  logic [DATA_SIZE-1:0]    wdata0;
  logic [DATA_SIZE-1:0]    wdata1;
  logic                    cs0;
  logic                    cs1;
  logic                    len0;
  logic                    len1;
  logic                    op0;
  logic                    op1;
  logic [DATA_SIZE-1:0]    rdata0;
  logic [DATA_SIZE-1:0]    rdata1;
  logic                    ack0;
  logic                    ack1;
  logic                    err0;
  logic                    err1;
  logic [1:0]              gnt;

  logic                    mc_valid;
  logic [ADDRESS_SIZE-1:0] mc_addr;
  logic [DATA_SIZE-1:0]    mc_wdata;
  logic                    mc_chip_select;
  logic                    mc_length_select;
  logic                    mc_op_select;
  logic [DATA_SIZE-1:0]    mc_rdata;
  logic                    mc_ack;
  logic                    mc_ready;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, cs0, cs1, len0, len1, op0, op1,
    input  mc_rdata, mc_ack, mc_ready,
    output rdata0, rdata1, ack0, ack1, err0, err1, gnt,
    output mc_valid, mc_addr, mc_wdata, mc_chip_select, mc_length_select, mc_op_select
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, cs0, cs1, len0, len1, op0, op1,
    output mc_rdata, mc_ack, mc_ready,
    input  rdata0, rdata1, ack0, ack1, err0, err1, gnt,
    input  mc_valid, mc_addr, mc_wdata, mc_chip_select, mc_length_select, mc_op_select
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// Two-port round-robin arbiter that sequences one command at a time into the RAM/ROM
// controller, waits for its ack (or a timeout) and returns a one-cycle ack/err to the winner.
module mem_request_arbiter #(
  parameter int unsigned ADDRESS_SIZE   = 24,
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst,
  mem_request_arbiter_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            last_grant_q;
  logic            sel_q;

  logic                    win;
  logic [ADDRESS_SIZE-1:0] win_addr;
  logic [DATA_SIZE-1:0]    win_wdata;
  logic                    win_cs;
  logic                    win_len;
  logic                    win_op;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = ~last_grant_q;
    end else begin
      win = bus.req1;
    end
    win_addr  = win ? bus.addr1  : bus.addr0;
    win_wdata = win ? bus.wdata1 : bus.wdata0;
    win_cs    = win ? bus.cs1    : bus.cs0;
    win_len   = win ? bus.len1   : bus.len0;
    win_op    = win ? bus.op1    : bus.op0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q              <= StIdle;
      cnt_q                <= '0;
      last_grant_q         <= 1'b1;
      sel_q                <= 1'b0;
      bus.gnt              <= 2'b00;
      bus.mc_valid         <= 1'b0;
      bus.mc_addr          <= '0;
      bus.mc_wdata         <= '0;
      bus.mc_chip_select   <= 1'b0;
      bus.mc_length_select <= 1'b0;
      bus.mc_op_select     <= 1'b0;
      bus.rdata0           <= '0;
      bus.rdata1           <= '0;
      bus.ack0             <= 1'b0;
      bus.ack1             <= 1'b0;
      bus.err0             <= 1'b0;
      bus.err1             <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if ((bus.req0 || bus.req1) && bus.mc_ready) begin
            sel_q                <= win;
            bus.gnt              <= win ? 2'b10 : 2'b01;
            bus.mc_addr          <= win_addr;
            bus.mc_wdata         <= win_wdata;
            bus.mc_chip_select   <= win_cs;
            bus.mc_length_select <= win_len;
            bus.mc_op_select     <= win_op;
            bus.mc_valid         <= 1'b1;
            state_q              <= StIssue;
          end
        end
        StIssue: begin
          bus.mc_valid <= 1'b0;
          cnt_q        <= '0;
          state_q      <= StWait;
        end
        StWait: begin
          // An ack arriving on the final timeout cycle still counts as success.
          if (bus.mc_ack) begin
            if (!bus.mc_op_select) begin
              if (sel_q) bus.rdata1 <= bus.mc_rdata;
              else       bus.rdata0 <= bus.mc_rdata;
            end
            if (sel_q) bus.ack1 <= 1'b1;
            else       bus.ack0 <= 1'b1;
            state_q <= StDone;
          end else if (cnt_q == CntLimit) begin
            if (sel_q) bus.err1 <= 1'b1;
            else       bus.err0 <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          bus.ack0     <= 1'b0;
          bus.ack1     <= 1'b0;
          bus.err0     <= 1'b0;
          bus.err1     <= 1'b0;
          bus.gnt      <= 2'b00;
          last_grant_q <= sel_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: hand-computed expectations for grant order,
// latency, write pass-through, timeout, backpressure and mid-transaction reset.
module tb_mem_request_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mem_request_arbiter_if #(.ADDRESS_SIZE(24), .DATA_SIZE(16)) bus ();

  mem_request_arbiter #(
    .ADDRESS_SIZE  (24),
    .DATA_SIZE     (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the command strobe; an expired budget is a failed comparison.
  task automatic wait_valid(input string tag);
    for (int n = 0; n < 20; n++) begin
      if (bus.mc_valid) break;
      tick();
    end
    check(tag, 32'(bus.mc_valid), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.cs0 = 1'b0;  bus.cs1 = 1'b0;
    bus.len0 = 1'b0; bus.len1 = 1'b0;
    bus.op0 = 1'b0;  bus.op1 = 1'b0;
    bus.mc_rdata = '0;
    bus.mc_ack   = 1'b0;
    bus.mc_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_valid", 32'(bus.mc_valid), 32'd0);
    check("rst_mc_addr", 32'(bus.mc_addr), 32'd0);
    check("rst_ack_err", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 32'd0);
    check("rst_rdata1", 32'(bus.rdata1), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_no_req_gnt", 32'(bus.gnt), 32'd0);

    // T2: both requesting from reset -> 0,1,0,1 with reads returning A000+i
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.addr0 = 24'h000100; bus.addr1 = 24'h000200;
    for (int i = 0; i < 4; i++) begin
      wait_valid("t2_wait_valid");
      check("t2_gnt", 32'(bus.gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("t2_mc_addr", 32'(bus.mc_addr), (i % 2 == 0) ? 32'h100 : 32'h200);
      tick();
      tick();
      tick();
      bus.mc_ack = 1'b1;
      bus.mc_rdata = 16'hA000 + 16'(i);
      tick();
      bus.mc_ack = 1'b0;
      check("t2_ack0", 32'(bus.ack0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t2_ack1", 32'(bus.ack1), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) check("t2_rdata0", 32'(bus.rdata0), 32'hA000 + 32'(i));
      else            check("t2_rdata1", 32'(bus.rdata1), 32'hA000 + 32'(i));
      if (i == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      tick();
    end

    // T1: single read, fastest completion
    bus.req0 = 1'b1; bus.addr0 = 24'h000010; bus.op0 = 1'b0;
    tick();
    check("t1_valid_t1", 32'(bus.mc_valid), 32'd1);
    check("t1_gnt", 32'(bus.gnt), 32'd1);
    check("t1_mc_addr", 32'(bus.mc_addr), 32'h10);
    check("t1_op", 32'(bus.mc_op_select), 32'd0);
    tick();
    check("t1_valid_pulse", 32'(bus.mc_valid), 32'd0);
    bus.mc_ack = 1'b1; bus.mc_rdata = 16'hBEEF;
    tick();
    check("t1_ack0_t3", 32'(bus.ack0), 32'd1);
    check("t1_rdata0", 32'(bus.rdata0), 32'hBEEF);
    check("t1_err0", 32'(bus.err0), 32'd0);
    bus.mc_ack = 1'b0; bus.req0 = 1'b0;
    tick();
    check("t1_ack0_pulse", 32'(bus.ack0), 32'd0);
    check("t1_gnt_clear", 32'(bus.gnt), 32'd0);

    // T3: write from port 1; rdata1 must hold its last read value
    bus.req1 = 1'b1; bus.addr1 = 24'h00ABCD; bus.wdata1 = 16'h1234;
    bus.cs1 = 1'b0; bus.len1 = 1'b1; bus.op1 = 1'b1;
    tick();
    check("t3_gnt", 32'(bus.gnt), 32'd2);
    check("t3_mc_addr", 32'(bus.mc_addr), 32'h00ABCD);
    check("t3_mc_wdata", 32'(bus.mc_wdata), 32'h1234);
    check("t3_op", 32'(bus.mc_op_select), 32'd1);
    check("t3_cs", 32'(bus.mc_chip_select), 32'd0);
    check("t3_len", 32'(bus.mc_length_select), 32'd1);
    tick();
    bus.mc_ack = 1'b1; bus.mc_rdata = 16'hFFFF;
    tick();
    check("t3_ack1", 32'(bus.ack1), 32'd1);
    check("t3_rdata1_held", 32'(bus.rdata1), 32'hA003);
    check("t3_mc_addr_stable", 32'(bus.mc_addr), 32'h00ABCD);
    bus.mc_ack = 1'b0; bus.req1 = 1'b0; bus.op1 = 1'b0;
    tick();

    // T4: no ack -> err0 at t+10 with TIMEOUT_CYCLES=8
    bus.req0 = 1'b1; bus.addr0 = 24'h000020;
    tick();
    check("t4_valid", 32'(bus.mc_valid), 32'd1);
    for (int k = 0; k < 8; k++) tick();
    check("t4_err0_early", 32'(bus.err0), 32'd0);
    tick();
    check("t4_err0_t10", 32'(bus.err0), 32'd1);
    check("t4_ack0", 32'(bus.ack0), 32'd0);
    check("t4_rdata0_held", 32'(bus.rdata0), 32'hBEEF);
    bus.req0 = 1'b0;
    tick();
    check("t4_err0_pulse", 32'(bus.err0), 32'd0);
    check("t4_gnt_idle", 32'(bus.gnt), 32'd0);

    // T5: mc_ready low blocks issue; a spurious mc_ack in IDLE is ignored
    bus.mc_ready = 1'b0; bus.req0 = 1'b1; bus.addr0 = 24'h000030; bus.mc_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_no_valid", 32'(bus.mc_valid), 32'd0);
    end
    check("t5_no_ack0", 32'(bus.ack0), 32'd0);
    bus.mc_ready = 1'b1; bus.mc_ack = 1'b0;
    tick();
    check("t5_valid", 32'(bus.mc_valid), 32'd1);
    tick();
    bus.mc_ack = 1'b1; bus.mc_rdata = 16'h5A5A;
    tick();
    check("t5_ack0", 32'(bus.ack0), 32'd1);
    check("t5_rdata0", 32'(bus.rdata0), 32'h5A5A);
    bus.mc_ack = 1'b0; bus.req0 = 1'b0;
    tick();

    // T6: asynchronous reset during WAIT
    bus.req0 = 1'b1; bus.addr0 = 24'h000040;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t6_gnt", 32'(bus.gnt), 32'd0);
    check("t6_mc_addr", 32'(bus.mc_addr), 32'd0);
    check("t6_rdata0", 32'(bus.rdata0), 32'd0);
    check("t6_ack_err", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.addr1 = 24'h000050; bus.op1 = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    check("t6_gnt1", 32'(bus.gnt), 32'd2);
    check("t6_mc_addr1", 32'(bus.mc_addr), 32'h50);
    check("t6_no_stale", 32'({bus.ack0, bus.err0}), 32'd0);
    tick();
    bus.mc_ack = 1'b1; bus.mc_rdata = 16'h7777;
    tick();
    check("t6_ack1", 32'(bus.ack1), 32'd1);
    check("t6_rdata1", 32'(bus.rdata1), 32'h7777);
    bus.mc_ack = 1'b0; bus.req1 = 1'b0;
    tick();
    check("t6_ack1_pulse", 32'(bus.ack1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
